rf_writeback_arbiter: RTL and testbench

- Write-side master for the register file. It drives the regfile's single write port (wena/waddr/wdata).
- Merges two result sources onto that port:
  - fixed-latency ALU results;
  - variable-latency load returns, buffered in a small FIFO.
- Exports a pending-write bitmap so issue logic can stall on registers with outstanding loads.
- Sits between the execute/memory stages and the regfile.

---
 rtl/rf_writeback_arbiter.sv | 147 ++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// Register-file write-back arbiter. It merges fixed-latency ALU results and
// FIFO-buffered load returns onto the single regfile write port, and exports
// a bitmap of registers that still have a load write outstanding.
module rf_writeback_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_alu_valid,
  output logic                             o_alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0]        i_alu_addr,
  input  logic [DATA_WIDTH-1:0]            i_alu_data,
  input  logic                             i_ld_valid,
  output logic                             o_ld_ready,
  input  logic [REG_ADDR_WIDTH-1:0]        i_ld_addr,
  input  logic [DATA_WIDTH-1:0]            i_ld_data,
  output logic                             o_wena,
  output logic [REG_ADDR_WIDTH-1:0]        o_waddr,
  output logic [DATA_WIDTH-1:0]            o_wdata,
  output logic [(1<<REG_ADDR_WIDTH)-1:0]   o_pending,
  output logic                             o_waw_err
);

  localparam int NUMREGS = 1 << REG_ADDR_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

  logic [REG_ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic [SC_W-1:0]           r_starve_cnt;
  logic                      r_wena;
  logic [REG_ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic                      r_wsrc_ld;
  logic                      r_waw_err;

  logic                      w_empty;
  logic                      w_alu_fire;
  logic                      w_push;
  logic                      w_pop;
  logic [NUMREGS-1:0]        w_pending;

  // Handshake readiness and the per-cycle grant decision (ALU first, then FIFO head)
  assign w_empty     = (r_count == '0);
  assign o_ld_ready  = !i_rst && (r_count < DEPTH_C);
  assign o_alu_ready = !i_rst && (r_starve_cnt != LIMIT_C);
  assign w_alu_fire  = i_alu_valid && o_alu_ready;
  assign w_push      = i_ld_valid && o_ld_ready;
  assign w_pop       = !w_alu_fire && !w_empty;

  // Pending bitmap: live FIFO entries plus a load sitting in the output register
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count) begin
        w_pending[r_fifo_addr[i]] = 1'b1;
      end
    end
    if (r_wena && r_wsrc_ld) begin
      w_pending[r_waddr] = 1'b1;
    end
  end

  // Load-return storage; contents are only meaningful between rd_ptr and count
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= i_ld_addr;
      r_fifo_data[r_wr_ptr] <= i_ld_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter: only ALU wins over a non-empty FIFO advance it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (w_alu_fire && !w_empty) begin
      r_starve_cnt <= r_starve_cnt + SC_W'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // Registered write port; address/data hold on idle cycles
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wena    <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wsrc_ld <= 1'b0;
    end else if (w_alu_fire) begin
      r_wena    <= 1'b1;
      r_waddr   <= i_alu_addr;
      r_wdata   <= i_alu_data;
      r_wsrc_ld <= 1'b0;
    end else if (w_pop) begin
      r_wena    <= 1'b1;
      r_waddr   <= r_fifo_addr[r_rd_ptr];
      r_wdata   <= r_fifo_data[r_rd_ptr];
      r_wsrc_ld <= 1'b1;
    end else begin
      r_wena    <= 1'b0;
      r_wsrc_ld <= 1'b0;
    end
  end

  // Sticky flag: ALU result accepted for a register with a load still in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_waw_err <= 1'b0;
    end else if (w_alu_fire && w_pending[i_alu_addr]) begin
      r_waw_err <= 1'b1;
    end
  end

  assign o_wena    = r_wena;
  assign o_waddr   = r_waddr;
  assign o_wdata   = r_wdata;
  assign o_pending = w_pending;
  assign o_waw_err = r_waw_err;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed vector table, hand-written corner
// sequences and constrained-random traffic against a queue-based reference.
module tb_rf_writeback_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic          i_clk;
  logic          i_rst;
  logic          i_alu_valid;
  logic          o_alu_ready;
  logic [AW-1:0] i_alu_addr;
  logic [DW-1:0] i_alu_data;
  logic          i_ld_valid;
  logic          o_ld_ready;
  logic [AW-1:0] i_ld_addr;
  logic [DW-1:0] i_ld_data;
  logic          o_wena;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic [15:0]   o_pending;
  logic          o_waw_err;

  rf_writeback_arbiter #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
    .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
    .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
    .o_wena(o_wena), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_pending(o_pending), .o_waw_err(o_waw_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic          av; logic [AW-1:0] aa; logic [DW-1:0] ad;
    logic          lv; logic [AW-1:0] la; logic [DW-1:0] ld;
    logic          ew; logic [AW-1:0] ea; logic [DW-1:0] ed;
    logic          ear; logic elr; logic [15:0] ep;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: buffered loads in arrival order and the write port
  wr_t           m_q[$];
  logic          m_wena, m_out_ld, m_waw;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_starve;

  // observed outputs of the most recent cycle, plus every write the DUT issued
  logic          obs_wena, obs_ar, obs_lr, obs_waw;
  logic [AW-1:0] obs_waddr;
  logic [DW-1:0] obs_wdata;
  logic [15:0]   obs_pend;
  wr_t           wlog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_wena = 1'b0; m_out_ld = 1'b0; m_waw = 1'b0;
    m_waddr = '0; m_wdata = '0; m_starve = 0;
  endfunction

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    p = '0;
    foreach (m_q[i]) p[m_q[i].addr] = 1'b1;
    if (m_wena && m_out_ld) p[m_waddr] = 1'b1;
    return p;
  endfunction

  function automatic void model_step(input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                     input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                                     input logic acc_a, input logic acc_l);
    logic [15:0] p;
    bit          nonempty;
    wr_t         h;
    p = model_pending();
    nonempty = (m_q.size() > 0);
    if (acc_a) begin
      if (p[aa]) m_waw = 1'b1;
      m_wena = 1'b1; m_waddr = aa; m_wdata = ad; m_out_ld = 1'b0;
      m_starve = nonempty ? m_starve + 1 : 0;
    end else if (nonempty) begin
      h = m_q.pop_front();
      m_wena = 1'b1; m_waddr = h.addr; m_wdata = h.data; m_out_ld = 1'b1;
      m_starve = 0;
    end else begin
      m_wena = 1'b0; m_out_ld = 1'b0; m_starve = 0;
    end
    if (acc_l) m_q.push_back({la, ldd});
  endfunction

  // one clock cycle: drive at negedge, compare against the model, advance at posedge
  task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                       output logic acc_a, output logic acc_l);
    logic e_ar, e_lr;
    @(negedge i_clk);
    i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
    i_ld_valid = lv;  i_ld_addr = la;  i_ld_data = ldd;
    #1;
    e_ar = (m_starve != LIMIT);
    e_lr = (m_q.size() < DEPTH);
    obs_wena = o_wena; obs_waddr = o_waddr; obs_wdata = o_wdata;
    obs_ar = o_alu_ready; obs_lr = o_ld_ready; obs_pend = o_pending; obs_waw = o_waw_err;
    check("alu_ready", o_alu_ready, e_ar);
    check("ld_ready", o_ld_ready, e_lr);
    check("pending", o_pending, model_pending());
    check("wena", o_wena, m_wena);
    check("waddr", o_waddr, m_waddr);
    check("wdata", o_wdata, m_wdata);
    check("waw_err", o_waw_err, m_waw);
    if (o_wena) wlog.push_back({o_waddr, o_wdata});
    acc_a = av && e_ar;
    acc_l = lv && e_lr;
    @(posedge i_clk);
    model_step(aa, ad, la, ldd, acc_a, acc_l);
  endtask

  task automatic idle(input int n);
    logic a, l;
    for (int c = 0; c < n; c++) cycle(1'b0, '0, '0, 1'b0, '0, '0, a, l);
  endtask

  // asynchronous reset pulse that starts between clock edges; call just after a posedge
  task automatic do_reset();
    i_alu_valid = 1'b0; i_ld_valid = 1'b0;
    #3;
    i_rst = 1'b1;
    #1;
    check("rst_wena", o_wena, 1'b0);
    check("rst_pending", o_pending, 16'h0);
    check("rst_alu_ready", o_alu_ready, 1'b0);
    check("rst_ld_ready", o_ld_ready, 1'b0);
    check("rst_waw_err", o_waw_err, 1'b0);
    check("rst_waddr", o_waddr, 4'h0);
    check("rst_wdata", o_wdata, 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    #1;
    check("post_rst_ld_ready", o_ld_ready, 1'b1);
    check("post_rst_alu_ready", o_alu_ready, 1'b1);
  endtask

  task automatic run_random(input int n);
    logic av, lv, acc_a, acc_l, hold_a, hold_l;
    logic [AW-1:0] aa, la;
    logic [DW-1:0] ad, ldd;
    hold_a = 1'b0; hold_l = 1'b0;
    av = 1'b0; lv = 1'b0; aa = '0; la = '0; ad = '0; ldd = '0;
    for (int c = 0; c < n; c++) begin
      if (!hold_a) begin
        av = ($urandom_range(0, 9) < 6);
        aa = AW'($urandom_range(0, 15));
        ad = $urandom();
      end
      if (!hold_l) begin
        lv = ($urandom_range(0, 9) < 6);
        la = AW'($urandom_range(0, 15));
        ldd = $urandom();
      end
      cycle(av, aa, ad, lv, la, ldd, acc_a, acc_l);
      hold_a = av && !acc_a;
      hold_l = lv && !acc_l;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (errors so far %0d)", n_errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    logic acc_a, acc_l, ldp;
    int   k, refused, nalu;
    wr_t  exp_s[7];
    wr_t  lq[$];

    i_rst = 1'b1;
    i_alu_valid = 1'b0; i_alu_addr = '0; i_alu_data = '0;
    i_ld_valid = 1'b0;  i_ld_addr = '0;  i_ld_data = '0;
    model_reset();
    #2;
    check("init_wena", o_wena, 1'b0);
    check("init_pending", o_pending, 16'h0);
    check("init_alu_ready", o_alu_ready, 1'b0);
    check("init_ld_ready", o_ld_ready, 1'b0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // ---- directed vector table: ALU-only, load-only, simultaneous ALU+load ----
    //          av  aa    ad            lv  la    ld            ew  ea    ed            ar  lr  pend
    tbl[0] = '{1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,       1'b0, 4'd0, 32'h0,       1'b1, 1'b1, 16'h0000};
    tbl[1] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 1'b1, 16'h0000};
    tbl[2] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd5, 32'h1234,    1'b0, 4'd3, 32'hDEADBEEF, 1'b1, 1'b1, 16'h0000};
    tbl[3] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b0, 4'd3, 32'hDEADBEEF, 1'b1, 1'b1, 16'h0020};
    tbl[4] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b1, 4'd5, 32'h1234,     1'b1, 1'b1, 16'h0020};
    tbl[5] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b0, 4'd5, 32'h1234,     1'b1, 1'b1, 16'h0000};
    tbl[6] = '{1'b1, 4'd2, 32'h11,       1'b1, 4'd2, 32'h22,      1'b0, 4'd5, 32'h1234,     1'b1, 1'b1, 16'h0000};
    tbl[7] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b1, 4'd2, 32'h11,       1'b1, 1'b1, 16'h0004};
    tbl[8] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b1, 4'd2, 32'h22,       1'b1, 1'b1, 16'h0004};
    tbl[9] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b0, 4'd2, 32'h22,       1'b1, 1'b1, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld, acc_a, acc_l);
      check($sformatf("tbl%0d_wena", i), obs_wena, tbl[i].ew);
      check($sformatf("tbl%0d_waddr", i), obs_waddr, tbl[i].ea);
      check($sformatf("tbl%0d_wdata", i), obs_wdata, tbl[i].ed);
      check($sformatf("tbl%0d_alu_ready", i), obs_ar, tbl[i].ear);
      check($sformatf("tbl%0d_ld_ready", i), obs_lr, tbl[i].elr);
      check($sformatf("tbl%0d_pending", i), obs_pend, tbl[i].ep);
    end

    // ---- starvation: ALU saturated, one load r9 must still get through ----
    do_reset();
    wlog.delete();
    k = 0; ldp = 1'b1; refused = 0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      cycle(1'b1, AW'(k + 1), 32'h1000 + k, ldp, 4'd9, 32'hA5A5A5A5, acc_a, acc_l);
      if (!obs_ar) refused++;
      if (acc_a) k++;
      if (acc_l) ldp = 1'b0;
    end
    check("starve_alu_done", k, 6);
    check("starve_alu_blocked_cycles", refused, 1);
    idle(3);
    exp_s[0] = {4'd1, 32'h1000}; exp_s[1] = {4'd2, 32'h1001};
    exp_s[2] = {4'd3, 32'h1002}; exp_s[3] = {4'd4, 32'h1003};
    exp_s[4] = {4'd9, 32'hA5A5A5A5};
    exp_s[5] = {4'd5, 32'h1004}; exp_s[6] = {4'd6, 32'h1005};
    check("starve_write_count", wlog.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < wlog.size()) check($sformatf("starve_write%0d", i), wlog[i], exp_s[i]);
    end

    // ---- FIFO full: five back-to-back loads under ALU pressure ----
    do_reset();
    wlog.delete();
    k = 0; nalu = 0; refused = 0;
    for (int c = 0; c < 60 && k < 5; c++) begin
      cycle(1'b1, AW'(8 + (nalu % 8)), 32'h2000 + nalu, 1'b1, AW'(k + 1), 32'hA000 + k + 1, acc_a, acc_l);
      if (!obs_lr) refused++;
      if (acc_a) nalu++;
      if (acc_l) k++;
    end
    check("full_loads_done", k, 5);
    check("full_ld_refused_seen", refused > 0, 1'b1);
    idle(10);
    lq.delete();
    k = 0;
    foreach (wlog[i]) begin
      if (wlog[i].addr >= 4'd1 && wlog[i].addr <= 4'd5) lq.push_back(wlog[i]);
      else if (wlog[i].addr >= 4'd8) k++;
    end
    check("full_alu_write_count", k, nalu);
    check("full_load_write_count", lq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < lq.size()) check($sformatf("full_load_order%0d", i), lq[i], {AW'(i + 1), 32'hA000 + i + 1});
    end

    // ---- WAW: ALU write to a register with a buffered load ----
    do_reset();
    cycle(1'b0, '0, '0, 1'b1, 4'd7, 32'h77, acc_a, acc_l);
    check("waw_before", obs_waw, 1'b0);
    cycle(1'b1, 4'd7, 32'h99, 1'b0, '0, '0, acc_a, acc_l);
    check("waw_pending7", obs_pend[7], 1'b1);
    check("waw_alu_accepted", acc_a, 1'b1);
    idle(1);
    check("waw_set", obs_waw, 1'b1);
    run_random(20);
    idle(4);
    check("waw_sticky", obs_waw, 1'b1);

    // ---- reset mid-operation: two loads buffered and a write in the output register ----
    do_reset();
    cycle(1'b1, 4'd12, 32'hC0, 1'b1, 4'd1, 32'h1, acc_a, acc_l);
    cycle(1'b1, 4'd13, 32'hC1, 1'b1, 4'd2, 32'h2, acc_a, acc_l);
    do_reset();
    wlog.delete();
    idle(8);
    check("midrst_no_stale_write", wlog.size(), 0);

    // ---- constrained-random traffic against the reference model ----
    for (int b = 0; b < 4; b++) begin
      run_random(150);
      do_reset();
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
